// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: widths, control-word bit positions and opcodes.
package sap1_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int CW_W   = 13;

   localparam int CW_EP  = 12;
   localparam int CW_HLT = 11;
   localparam int CW_LM  = 10;
   localparam int CW_CP  = 9;
   localparam int CW_CE  = 8;
   localparam int CW_EI  = 7;
   localparam int CW_LI  = 6;
   localparam int CW_LA  = 5;
   localparam int CW_EA  = 4;
   localparam int CW_EU  = 3;
   localparam int CW_SU  = 2;
   localparam int CW_LB  = 1;
   localparam int CW_LO  = 0;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;
endpackage

// File: rtl/sap1_ram16x8.sv
// 16x8 program/data RAM: asynchronous read, synchronous write with enable.
module sap1_ram16x8
   import sap1_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read-during-write returns the old word; the new one appears next cycle.
   assign rdata = mem[raddr];
endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 register/bus datapath driven by the 13-bit control word.
// Optional contention checker enabled by defining SAP1_BUS_CHECK_EN.
module sap1_datapath
   import sap1_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [CW_W-1:0]   cw,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [3:0]        opcode,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] bus,
   output logic              halted,
   output logic              bus_err
);
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] ram_rd;
   logic [DATA_W-1:0] alu_y;

   function automatic logic [DATA_W-1:0] alu_op(input logic signed [DATA_W-1:0] x,
                                                input logic signed [DATA_W-1:0] y,
                                                input logic su);
      logic signed [DATA_W-1:0] r;
      r = su ? (x - y) : (x + y);
      return r;
   endfunction

   sap1_ram16x8 u_ram (
      .clk   (clk),
      .we    (prog_we & ~halted),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (mar),
      .rdata (ram_rd)
   );

   assign alu_y = alu_op(a, b, cw[CW_SU]);

   // Fixed driver priority resolves any contention deterministically.
   always_comb begin
      bus = '0;
      if (cw[CW_EP])      bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
      else if (cw[CW_CE]) bus = ram_rd;
      else if (cw[CW_EI]) bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
      else if (cw[CW_EA]) bus = a;
      else if (cw[CW_EU]) bus = alu_y;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= '0;
         mar      <= '0;
         ir       <= '0;
         a        <= '0;
         b        <= '0;
         out_data <= '0;
         halted   <= 1'b0;
      end else if (!halted) begin
         if (cw[CW_HLT]) halted   <= 1'b1;
         if (cw[CW_CP])  pc       <= pc + 4'd1;
         if (cw[CW_LM])  mar      <= bus[ADDR_W-1:0];
         if (cw[CW_LI])  ir       <= bus;
         if (cw[CW_LA])  a        <= bus;
         if (cw[CW_LB])  b        <= bus;
         if (cw[CW_LO])  out_data <= bus;
      end
   end

   assign opcode = ir[DATA_W-1:DATA_W-4];

`ifdef SAP1_BUS_CHECK_EN
   logic [2:0] n_drv;

   always_comb begin
      n_drv = {2'b00, cw[CW_EP]} + {2'b00, cw[CW_CE]} + {2'b00, cw[CW_EI]}
            + {2'b00, cw[CW_EA]} + {2'b00, cw[CW_EU]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               bus_err <= 1'b0;
      else if (n_drv > 3'd1) bus_err <= 1'b1;
   end
`else
   assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_sap1_datapath.sv
// Directed and randomized bench for sap1_datapath against a behavioural model.
module tb_sap1_datapath;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [12:0] cw = '0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [7:0]  prog_data = '0;
   logic [3:0]  opcode;
   logic [7:0]  out_data;
   logic [7:0]  bus;
   logic        halted;
   logic        bus_err;

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   logic [7:0] m_ram [16];
   logic [3:0] m_pc, m_mar;
   logic [7:0] m_ir, m_a, m_b, m_out;
   logic       m_halt, m_err;
   logic [7:0] obs_bus;

   sap1_datapath dut (
      .clk       (clk),
      .rst       (rst),
      .cw        (cw),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .opcode    (opcode),
      .out_data  (out_data),
      .bus       (bus),
      .halted    (halted),
      .bus_err   (bus_err)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_bus(input logic [12:0] c);
      if (c[12])     return {4'h0, m_pc};
      else if (c[8]) return m_ram[m_mar];
      else if (c[7]) return {4'h0, m_ir[3:0]};
      else if (c[4]) return m_a;
      else if (c[3]) return c[2] ? 8'(m_a - m_b) : 8'(m_a + m_b);
      return 8'h00;
   endfunction

   task automatic model_reset();
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
      m_halt = 0; m_err = 0;
   endtask

   task automatic model_edge(input logic [12:0] c, input logic we,
                             input logic [3:0] wa, input logic [7:0] wd);
      logic [7:0] bv;
      int drv;
      bv = model_bus(c);
      drv = int'(c[12]) + int'(c[8]) + int'(c[7]) + int'(c[4]) + int'(c[3]);
`ifdef SAP1_BUS_CHECK_EN
      if (drv > 1) m_err = 1;
`endif
      if (!m_halt) begin
         if (we) m_ram[wa] = wd;
         if (c[9]) m_pc = m_pc + 4'd1;
         if (c[10]) m_mar = bv[3:0];
         if (c[6]) m_ir = bv;
         if (c[5]) m_a = bv;
         if (c[1]) m_b = bv;
         if (c[0]) m_out = bv;
         if (c[11]) m_halt = 1;
      end
   endtask

   // One clock cycle: bus checked before the edge, registered outputs after.
   task automatic step(input logic [12:0] c, input logic we,
                       input logic [3:0] wa, input logic [7:0] wd);
      @(negedge clk);
      cw = c; prog_we = we; prog_addr = wa; prog_data = wd;
      #1;
      obs_bus = bus;
      chk("bus", bus, model_bus(c));
      @(posedge clk);
      model_edge(c, we, wa, wd);
      #1;
      chk("out_data", out_data, m_out);
      chk("opcode", {4'h0, opcode}, {4'h0, m_ir[7:4]});
      chk("halted", {7'h0, halted}, {7'h0, m_halt});
      chk("bus_err", {7'h0, bus_err}, {7'h0, m_err});
   endtask

   task automatic do_reset();
      @(negedge clk);
      cw = '0; prog_we = 0; rst = 1'b1;
      #1;
      model_reset();
      chk("rst_opcode", {4'h0, opcode}, 8'h00);
      chk("rst_out", out_data, 8'h00);
      chk("rst_halted", {7'h0, halted}, 8'h00);
      chk("rst_bus_err", {7'h0, bus_err}, 8'h00);
      chk("rst_bus", bus, 8'h00);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_a(input logic [7:0] v);
      step(13'h0000, 1'b1, m_mar, v);
      step(13'h0120, 1'b0, 4'h0, 8'h00);
   endtask

   task automatic load_b(input logic [7:0] v);
      step(13'h0000, 1'b1, m_mar, v);
      step(13'h0102, 1'b0, 4'h0, 8'h00);
   endtask

   initial begin
      logic [12:0] c;
      logic [7:0] saved;
      logic [7:0] exp_err;

      do_reset();
      // Program all of RAM while reset is held.
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         prog_we = 1'b1; prog_addr = 4'(i);
         prog_data = (i == 0) ? 8'h19 : 8'($urandom);
         @(posedge clk);
         m_ram[i] = prog_data;
      end
      @(negedge clk);
      prog_we = 1'b0; rst = 1'b0;
      model_reset();

      // Fetch
      step(13'h1400, 0, 0, 0);
      step(13'h0340, 0, 0, 0);
      chk("fetch_opcode", {4'h0, opcode}, 8'h01);
      step(13'h1000, 0, 0, 0);
      chk("fetch_pc", obs_bus, 8'h01);
      step(13'h0100, 0, 0, 0);
      chk("fetch_mar_ram0", obs_bus, 8'h19);
      step(13'h0080, 0, 0, 0);
      chk("ir_operand", obs_bus, 8'h09);

      // ALU add and subtract
      load_a(8'hF0); load_b(8'h20);
      step(13'h0028, 0, 0, 0);
      step(13'h0010, 0, 0, 0);
      chk("alu_add_wrap", obs_bus, 8'h10);
      load_a(8'h05); load_b(8'h07);
      step(13'h002C, 0, 0, 0);
      step(13'h0011, 0, 0, 0);
      chk("alu_sub_neg", obs_bus, 8'hFE);
      chk("out_load", out_data, 8'hFE);

      // PC wrap and Ep+Cp
      do_reset();
      for (int i = 0; i < 16; i++) step(13'h0200, 0, 0, 0);
      step(13'h1000, 0, 0, 0);
      chk("pc_wrap", obs_bus, 8'h00);
      step(13'h1200, 0, 0, 0);
      chk("ep_cp_old_pc", obs_bus, 8'h00);
      step(13'h1000, 0, 0, 0);
      chk("ep_cp_incr", obs_bus, 8'h01);

      // Halt suppresses loads and programming
      load_a(8'h33);
      saved = m_ram[m_mar];
      step(13'h0800, 0, 0, 0);
      chk("halt_set", {7'h0, halted}, 8'h01);
      step(13'h0120, 1'b1, m_mar, 8'hC5);
      step(13'h0010, 0, 0, 0);
      chk("halt_a_kept", obs_bus, 8'h33);
      step(13'h0100, 0, 0, 0);
      chk("halt_ram_kept", obs_bus, saved);
      do_reset();

      // Contention
      step(13'h0200, 0, 0, 0);
      step(13'h0200, 0, 0, 0);
      step(13'h1100, 0, 0, 0);
      chk("contention_bus", obs_bus, 8'h02);
`ifdef SAP1_BUS_CHECK_EN
      exp_err = 8'h01;
`else
      exp_err = 8'h00;
`endif
      chk("contention_err", {7'h0, bus_err}, exp_err);
      step(13'h0000, 0, 0, 0);
      chk("contention_sticky", {7'h0, bus_err}, exp_err);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         c = 13'($urandom);
         if ($urandom_range(0, 39) != 0) c[11] = 1'b0;
         step(c, ($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom));
         if ((m_halt && $urandom_range(0, 5) == 0) || (n % 150 == 149)) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sap1_datapath.md
# sap1_datapath

Register-and-bus datapath for the SAP-1 CPU: the consumer of the 13-bit control word produced by the controller. Each cycle it decodes the control word into bus-driver enables and register loads, moves one byte over the shared 8-bit bus, and returns the instruction opcode to the controller. It holds PC, MAR, 16x8 RAM, IR, accumulator A, B, the add/subtract ALU and the output register.

## Interface
- No parameters. Widths are fixed: data 8, address 4, control word 13.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cw  in  13  control word: [12] Ep PC→bus, [11] HLT, [10] Lm MAR load, [9] Cp PC increment, [8] CE RAM→bus, [7] Ei IR operand→bus, [6] Li IR load, [5] La A load, [4] Ea A→bus, [3] Eu ALU→bus, [2] Su subtract, [1] Lb B load, [0] Lo output load.
- prog_we  in  1  RAM programming write strobe.
- prog_addr  in  4  programming address.
- prog_data  in  8  programming data.
- opcode  out  4  IR[7:4], to controller.
- out_data  out  8  output register.
- bus  out  8  current bus value (debug/monitor).
- halted  out  1  sticky halt flag.
- bus_err  out  1  sticky bus-contention flag (see Configuration).

## Operation
- Bus is combinational from cw. Driver priority: Ep {4'h0,PC} > CE RAM[MAR] > Ei {4'h0,IR[3:0]} > Ea A > Eu ALU. With no driver, bus = 8'h00.
- ALU is combinational: Su=0 gives A+B mod 256; Su=1 gives A−B mod 256 (two's complement). No carry or flags.
- Loads sample the bus at the clock edge: Lm writes MAR ← bus[3:0], Li writes IR ← bus, La writes A ← bus, Lb writes B ← bus, Lo writes out_data ← bus. Several loads in one cycle all take the same bus value.
- Cp: PC ← PC+1, wrapping 15→0. If Ep and Cp are both set, the bus carries the old PC and PC increments.
- La with Ea/Eu: A takes the pre-edge bus value, which is well defined.
- HLT: at the edge with cw[11]=1, halted ← 1. While halted=1, every load, Cp and programming write is suppressed. The bus stays combinational. Only rst clears halted.
- RAM: reads are asynchronous at MAR. A programming write occurs at the edge when prog_we=1 and halted=0, independent of cw. If a RAM write hits the address being read, the bus shows the old data in that cycle.
- Reset values: PC, MAR, IR, A, B, out_data = 0; opcode = 4'h0; halted = 0; bus_err = 0. RAM contents are not reset. Programming while rst is held is permitted; writes proceed during reset.
- Reset mid-instruction: all registers clear immediately and asynchronously. The controller restarts the fetch.

## Timing
- cw to bus: same cycle, combinational.
- Load to register visible: 1 cycle. opcode follows the Li edge.
- Controller contract: IR loads on T2, and opcode is stable from T3 onward.
- Programming write is readable via MAR on the next cycle.
- halted asserts 1 cycle after the HLT control word is presented.

## Configuration
- SAP1_BUS_CHECK_EN defined: bus_err is set at any edge where more than one of Ep, CE, Ei, Ea, Eu is 1. It is sticky until rst. Bus priority is unchanged.
- Not defined: bus_err is tied 0 and there is no checker logic.

## Structure
- Shared package sap1_pkg holds:
  - cw bit-index constants (CW_EP … CW_LO), shared with the controller.
  - Opcode constants LDA=0, ADD=1, SUB=2, OUT=E, HLT=F.
  - Width constants.
- Sub-module sap1_ram16x8: asynchronous read port plus synchronous programming write with enable.

## Test plan
- Reset → PC, A, B, out_data, opcode, halted, bus_err all 0 and bus = 00.
- Program RAM[0]=0x19, then cw 0x1400 followed by 0x0340 → MAR=0, IR=0x19, opcode=1, PC=1.
- A=0xF0, B=0x20, cw 0x0028 → A=0x10. Then A=0x05, B=0x07, cw 0x002C → A=0xFE.
- Sixteen cycles of cw 0x0200 from reset → PC returns to 0. A cycle of cw 0x1200 → bus shows old PC and PC increments.
- cw 0x0800 → halted=1. Then cw 0x0120 and prog_we → A and RAM unchanged. rst → halted=0.
- cw 0x1100 (Ep+CE) → bus = PC. bus_err=1 next cycle with SAP1_BUS_CHECK_EN, 0 without.
